counter_sched: RTL and testbench

//   Round-robin scheduler that shares one WIDTH-bit up-counter between NREQ requesters.
//   - A requester submits a job: a start value plus a terminal (limit) value.
//   - The block arbitrates, loads the counter with start, and counts up until it equals limit.
//   - It then pulses done to the owner and releases the counter.
//   - Sits between software/stimulus agents and the shared counting datapath.

---
 rtl/counter_sched_pkg.sv | 21 ++
 rtl/counter_sched_arbiter.sv | 32 +++
 rtl/counter_sched.sv | 141 ++++++++++++++
 tb/tb_counter_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and sizing helpers for the round-robin counter scheduler.
package counter_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(NREQ_DEF);

endpackage

// File: rtl/counter_sched_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i, wrapping.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_valid_o
);

  logic [IDX_W-1:0] cand_idx_s;

  // Scan upward from the pointer; the first hit wins and later hits are ignored.
  always_comb begin
    win_idx_o   = '0;
    win_valid_o = 1'b0;
    cand_idx_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_idx_s = IDX_W'((int'(rr_ptr_i) + k) % NREQ);
      if (!win_valid_o && req_i[cand_idx_s]) begin
        win_valid_o = 1'b1;
        win_idx_o   = cand_idx_s;
      end else begin
        win_valid_o = win_valid_o;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter between NREQ requesters.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] start_val,
  input  logic [NREQ*WIDTH-1:0] limit_val,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      value,
  output logic [NREQ-1:0]       done
);

  localparam int IDX_W = idx_w(NREQ);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] win_idx_s;
  logic             win_valid_s;
  logic [NREQ-1:0]  win_onehot_s;
  logic             owner_req_s;
  logic [WIDTH-1:0] start_arr_s [NREQ];
  logic [WIDTH-1:0] limit_arr_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign start_arr_s[g] = start_val[g*WIDTH +: WIDTH];
    assign limit_arr_s[g] = limit_val[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i       (req),
    .rr_ptr_i    (rr_ptr_q),
    .win_idx_o   (win_idx_s),
    .win_valid_o (win_valid_s)
  );

  assign win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign owner_req_s  = req[idx_q];

  // Next-state, job latch and counter update; the owner dropping its request aborts LOAD/RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    start_d  = start_q;
    limit_d  = limit_q;
    count_d  = count_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          state_d  = LOAD;
          idx_d    = win_idx_s;
          start_d  = start_arr_s[win_idx_s];
          limit_d  = limit_arr_s[win_idx_s];
          grant_d  = win_onehot_s;
          rr_ptr_d = IDX_W'((int'(win_idx_s) + 1) % NREQ);
        end else begin
          grant_d = '0;
        end
      end
      LOAD: begin
        if (!owner_req_s) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = RUN;
          count_d = start_q;
        end
      end
      RUN: begin
        if (!owner_req_s) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (count_q == limit_q) begin
          state_d = DONE;
        end else begin
          count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    // done is registered so it lines up with the cycle spent in DONE
    done_d = (state_d == DONE) ? grant_d : '0;
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      start_q  <= '0;
      limit_q  <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      start_q  <= start_d;
      limit_q  <= limit_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign value = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic against a job-level model.
module tb_counter_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] start_val = '0;
  logic [N*W-1:0] limit_val = '0;
  logic [N-1:0]   grant;
  logic           busy;
  logic [W-1:0]   value;
  logic [N-1:0]   done;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Job-level model: owner, latched start, distance D, and age in edges since the grant.
  bit           m_active;
  int           m_owner;
  int           m_ptr;
  int           m_dist;
  int           m_age;
  logic [W-1:0] m_start;
  logic [W-1:0] m_value;

  counter_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .start_val (start_val),
    .limit_val (limit_val),
    .grant     (grant),
    .busy      (busy),
    .value     (value),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_job(input int i, input logic [W-1:0] s, input logic [W-1:0] l);
    start_val[i*W +: W] = s;
    limit_val[i*W +: W] = l;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_dist   = 0;
    m_age    = 0;
    m_start  = '0;
    m_value  = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] lim;
    logic [W-1:0] diff;
    int           k;
    bit           found;
    if (m_active) begin
      if (m_age <= m_dist + 1 && !req[m_owner]) begin
        m_active = 1'b0;
      end else begin
        m_age++;
        if (m_age == m_dist + 3) begin
          m_active = 1'b0;
        end else begin
          k       = (m_age - 1 < m_dist) ? m_age - 1 : m_dist;
          m_value = m_start + W'(k);
        end
      end
    end else begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        int c;
        c = (m_ptr + j) % N;
        if (!found && req[c]) begin
          found    = 1'b1;
          m_active = 1'b1;
          m_owner  = c;
          m_age    = 0;
          m_start  = start_val[c*W +: W];
          lim      = limit_val[c*W +: W];
          diff     = lim - m_start;
          m_dist   = int'(diff);
          m_ptr    = (c + 1) % N;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_grant", grant, m_active ? onehot(m_owner) : '0);
        chk("m_busy",  busy,  m_active);
        chk("m_value", value, m_value);
        chk("m_done",  done,  (m_active && m_age == m_dist + 2) ? onehot(m_owner) : '0);
      end
    end
  end

  task automatic job_d3(input int i, input logic [W-1:0] s, input logic [W-1:0] l,
                        input logic [W-1:0] ev [4], input string tag);
    set_job(i, s, l);
    req = onehot(i);
    @(negedge clk);
    chk({tag, "_grant"}, grant, onehot(i));
    chk({tag, "_busy"}, busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_value"}, value, ev[k]);
      chk({tag, "_nodone"}, done, '0);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, onehot(i));
    chk({tag, "_hold"}, value, ev[3]);
    chk({tag, "_grant_held"}, grant, onehot(i));
    req = '0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_grant"}, grant, '0);
    chk({tag, "_idle_done"}, done, '0);
  endtask

  initial begin
    logic [W-1:0] ev [4];
    logic [N-1:0] order [$];
    logic [N-1:0] prevg;
    int           dcnt [N];
    int           dtot;
    bit           hit;
    logic [W-1:0] s;

    repeat (2) @(negedge clk);
    chk("rst_grant", grant, '0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_value", value, '0);
    chk("rst_done",  done,  '0);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // Single job, start 2 limit 5
    ev = '{16'd2, 16'd3, 16'd4, 16'd5};
    job_d3(0, 16'd2, 16'd5, ev, "t1");

    // Equal endpoints on requester 2
    set_job(2, 16'd9, 16'd9);
    req = 4'b0100;
    @(negedge clk);
    chk("t2_grant", grant, 4'b0100);
    @(negedge clk);
    chk("t2_value", value, 16'd9);
    chk("t2_nodone", done, 4'b0000);
    @(negedge clk);
    chk("t2_done", done, 4'b0100);
    chk("t2_hold", value, 16'd9);
    req = '0;
    @(negedge clk);
    chk("t2_idle", busy, 1'b0);

    // Contention from a freshly reset pointer
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < N; i++) set_job(i, 16'd0, 16'd0);
    req   = 4'b1111;
    prevg = '0;
    dtot  = 0;
    for (int i = 0; i < N; i++) dcnt[i] = 0;
    for (int c = 0; c < 60 && !(order.size() >= 5 && dtot >= 5); c++) begin
      @(negedge clk);
      if (grant != '0 && prevg == '0) order.push_back(grant);
      prevg = grant;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          dcnt[i]++;
          dtot++;
        end
      end
    end
    req = '0;
    chk("t3_ngrants", order.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("t3_order", (order.size() > k) ? order[k] : '0, onehot(k % N));
    chk("t3_done0", dcnt[0], 2);
    for (int i = 1; i < N; i++) chk("t3_doneN", dcnt[i], 1);
    repeat (2) @(negedge clk);

    // Wrap through zero
    ev = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    job_d3(0, 16'hFFFE, 16'h0001, ev, "t4");

    // Abort by requester 1 while requester 2 waits
    set_job(1, 16'd0, 16'd20);
    set_job(2, 16'd100, 16'd102);
    req = 4'b0110;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (value == 16'd3 && grant == 4'b0010) hit = 1'b1;
    end
    chk("t5_reach3", hit, 1'b1);
    req = 4'b0100;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_grant0", grant, 4'b0000);
    chk("t5_nodone", done, 4'b0000);
    chk("t5_hold", value, 16'd3);
    @(negedge clk);
    chk("t5_grant2", grant, 4'b0100);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (done != '0) hit = 1'b1;
    end
    chk("t5_done2", hit, 1'b1);
    req = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a run
    set_job(0, 16'd0, 16'd50);
    req = 4'b0001;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (value == 16'd7) hit = 1'b1;
    end
    chk("t6_reach7", hit, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_grant", grant, '0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, '0);
    chk("t6_value", value, '0);
    set_job(0, 16'd0, 16'd0);
    set_job(3, 16'd0, 16'd0);
    req = 4'b1001;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t6_first", grant, 4'b0001);
    req = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic, including mid-job input changes and aborts
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 2000) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            req[i] = 1'b0;
          end else if ($urandom_range(0, 7) == 0) begin
            s = W'($urandom);
            set_job(i, s, s + W'($urandom_range(0, 9)));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          s = W'($urandom);
          set_job(i, s, s + W'($urandom_range(0, 9)));
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (20) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
